stg_ia: RTL and testbench

- Instruction-address stage of the diad pipeline; the first stage, upstream of the IF stage.
- Owns the architectural fetch PC (r_ia_pc), advances it each cycle and applies EX-stage branch redirects.
- Handles IF backpressure and halt.
- Presents {pc, valid, flush} to the IA/IF pipeline register.

---
 rtl/stg_ia_pkg.sv | 17 +
 rtl/stg_ia_btb.sv | 50 +++++
 rtl/stg_ia.sv | 125 ++++++++++++
 tb/tb_stg_ia.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/stg_ia_pkg.sv
// Shared sizes and state encoding for the diad instruction-address (IA) stage.
// Also carries the BTB geometry used when IA_BTB_EN is defined.
package stg_ia_pkg;

    localparam int IA_PC_W      = 12;
    localparam int IA_BUB_W     = 2;
    localparam int IA_BTB_DEPTH = 4;
    localparam int IA_BTB_IDX_W = 2;

    typedef enum logic [1:0] {
        IA_BOOT   = 2'd0,
        IA_RUN    = 2'd1,
        IA_BUBBLE = 2'd2,
        IA_HALT   = 2'd3
    } ia_state_t;

endpackage

// File: rtl/stg_ia_btb.sv
// 4-entry direct-mapped branch target buffer for the IA stage.
// Compiled only when IA_BTB_EN is defined; the default build leaves this file empty.
`ifdef IA_BTB_EN
module stg_ia_btb
    import stg_ia_pkg::*;
#(
    parameter int PC_W = IA_PC_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic [PC_W-1:0] wr_pc,
    input  logic [PC_W-1:0] wr_target,
    input  logic [PC_W-1:0] rd_pc,
    output logic            hit,
    output logic [PC_W-1:0] target
);

    localparam int TAG_W = PC_W - IA_BTB_IDX_W;

    logic [IA_BTB_DEPTH-1:0] vld;
    logic [TAG_W-1:0]        tag_mem [IA_BTB_DEPTH];
    logic [PC_W-1:0]         tgt_mem [IA_BTB_DEPTH];
    logic [IA_BTB_IDX_W-1:0] wr_idx;
    logic [IA_BTB_IDX_W-1:0] rd_idx;

    assign wr_idx = wr_pc[IA_BTB_IDX_W-1:0];
    assign rd_idx = rd_pc[IA_BTB_IDX_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else if (wr_en) begin
            vld[wr_idx] <= 1'b1;
        end
    end

    // NOTE: tag/target storage has no reset; the valid bits alone qualify an entry.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx] <= wr_pc[PC_W-1:IA_BTB_IDX_W];
            tgt_mem[wr_idx] <= wr_target;
        end
    end

    assign hit    = vld[rd_idx] && (tag_mem[rd_idx] == rd_pc[PC_W-1:IA_BTB_IDX_W]);
    assign target = tgt_mem[rd_idx];

endmodule
`endif

// File: rtl/stg_ia.sv
// Instruction-address stage: owns the fetch PC, applies EX redirects, stall and halt.
// Define IA_BTB_EN to add a small BTB that predicts the next PC in RUN.
module stg_ia
    import stg_ia_pkg::*;
#(
    parameter int              PC_W             = IA_PC_W,
    parameter logic [PC_W-1:0] RESET_PC         = '0,
    parameter int              REDIRECT_BUBBLES = 1
) (
    input  logic            iw_clk,
    input  logic            iw_rst,
    input  logic            iw_stall,
    input  logic            iw_branch_taken,
    input  logic [PC_W-1:0] iw_branch_pc,
    input  logic [PC_W-1:0] iw_branch_src_pc,
    input  logic            iw_halt,
    output logic [PC_W-1:0] ow_pc,
    output logic            ow_valid,
    output logic            ow_flush,
    output logic            ow_pred_taken
);

    localparam logic [IA_BUB_W-1:0] BUB_LOAD = IA_BUB_W'(REDIRECT_BUBBLES);
    localparam logic [IA_BUB_W-1:0] BUB_ONE  = IA_BUB_W'(1);

    ia_state_t           state;
    logic [PC_W-1:0]     r_ia_pc;
    logic                r_valid;
    logic                r_flush;
    logic                r_pred;
    logic [IA_BUB_W-1:0] bub_cnt;

    logic                btb_hit;
    logic [PC_W-1:0]     btb_target;

`ifdef IA_BTB_EN
    logic btb_wr;

    // Training follows the same gating as the redirect itself.
    assign btb_wr = iw_branch_taken && !iw_halt && (state != IA_HALT);

    stg_ia_btb #(.PC_W(PC_W)) u_btb (
        .clk       (iw_clk),
        .rst       (iw_rst),
        .wr_en     (btb_wr),
        .wr_pc     (iw_branch_src_pc),
        .wr_target (iw_branch_pc),
        .rd_pc     (r_ia_pc),
        .hit       (btb_hit),
        .target    (btb_target)
    );
`else
    logic unused_src_pc;

    assign unused_src_pc = ^iw_branch_src_pc;
    assign btb_hit       = 1'b0;
    assign btb_target    = '0;
`endif

    // NOTE: all state here is sequential, so every assignment is non-blocking.
    always_ff @(posedge iw_clk or posedge iw_rst) begin
        if (iw_rst) begin
            state   <= IA_BOOT;
            r_ia_pc <= RESET_PC;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_pred  <= 1'b0;
            bub_cnt <= '0;
        end else if (state == IA_HALT) begin
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_pred  <= 1'b0;
        end else if (iw_halt) begin
            state   <= IA_HALT;
            r_valid <= 1'b0;
            r_flush <= 1'b0;
            r_pred  <= 1'b0;
        end else if (iw_branch_taken) begin
            // A redirect wins over stall and over any BTB prediction.
            r_ia_pc <= iw_branch_pc;
            r_flush <= 1'b1;
            r_pred  <= 1'b0;
            if (REDIRECT_BUBBLES > 0) begin
                state   <= IA_BUBBLE;
                bub_cnt <= BUB_LOAD;
                r_valid <= 1'b0;
            end else begin
                state   <= IA_RUN;
                r_valid <= 1'b1;
            end
        end else begin
            r_flush <= 1'b0;
            case (state)
                IA_BOOT: begin
                    state   <= IA_RUN;
                    r_valid <= 1'b1;
                end
                IA_RUN: begin
                    if (!iw_stall) begin
                        r_ia_pc <= btb_hit ? btb_target : r_ia_pc + PC_W'(1);
                        r_pred  <= btb_hit;
                        r_valid <= 1'b1;
                    end
                end
                IA_BUBBLE: begin
                    if (!iw_stall) begin
                        if (bub_cnt == BUB_ONE) begin
                            state   <= IA_RUN;
                            r_valid <= 1'b1;
                        end
                        bub_cnt <= bub_cnt - BUB_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign ow_pc         = r_ia_pc;
    assign ow_valid      = r_valid;
    assign ow_flush      = r_flush;
    assign ow_pred_taken = r_pred;

endmodule

// File: tb/tb_stg_ia.sv
// Testbench for stg_ia in its default build (IA_BTB_EN undefined, default parameters).
module tb_stg_ia;

    localparam int PC_W = 12;
    localparam int RB   = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            stall;
    logic            br;
    logic [PC_W-1:0] bpc;
    logic [PC_W-1:0] src_pc;
    logic            halt;
    logic [PC_W-1:0] pc;
    logic            valid;
    logic            flush;
    logic            pred;

    always #5 clk = ~clk;

    stg_ia dut (
        .iw_clk           (clk),
        .iw_rst           (rst),
        .iw_stall         (stall),
        .iw_branch_taken  (br),
        .iw_branch_pc     (bpc),
        .iw_branch_src_pc (src_pc),
        .iw_halt          (halt),
        .ow_pc            (pc),
        .ow_valid         (valid),
        .ow_flush         (flush),
        .ow_pred_taken    (pred)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [PC_W-1:0] epc,
                              input logic ev, input logic ef);
        check({tag, ".pc"},    32'(pc),    32'(epc));
        check({tag, ".valid"}, 32'(valid), 32'(ev));
        check({tag, ".flush"}, 32'(flush), 32'(ef));
        check({tag, ".pred"},  32'(pred),  32'(0));
    endtask

    // Apply one cycle of inputs, then sample just after the rising edge.
    task automatic drive(input logic s, input logic b, input logic h, input logic [PC_W-1:0] p);
        stall  = s;
        br     = b;
        halt   = h;
        bpc    = p;
        src_pc = p ^ 12'h5a5;
        @(posedge clk);
        #1;
    endtask

    // Assert reset away from any edge, check it acts at once, release, check BOOT.
    task automatic do_reset(input string tag);
        stall = 1'b0; br = 1'b0; halt = 1'b0; bpc = '0; src_pc = '0;
        rst = 1'b1;
        #2;
        expect_out({tag, ".async"}, 12'h000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        expect_out({tag, ".boot"}, 12'h000, 1'b0, 1'b0);
    endtask

    // Reference model: fetch PC plus count of bubbles still owed after a redirect.
    logic [PC_W-1:0] m_pc;
    logic            m_valid;
    logic            m_flush;
    int              m_bub;
    bit              m_boot;
    bit              m_halted;

    function automatic void model_reset();
        m_pc = '0; m_valid = 1'b0; m_flush = 1'b0;
        m_bub = 0; m_boot = 1'b1; m_halted = 1'b0;
    endfunction

    function automatic void model_step(input logic s, input logic b, input logic h,
                                       input logic [PC_W-1:0] p);
        if (m_halted) begin
            m_valid = 1'b0; m_flush = 1'b0;
        end else if (h) begin
            m_halted = 1'b1; m_valid = 1'b0; m_flush = 1'b0;
        end else if (b) begin
            m_pc = p; m_flush = 1'b1; m_bub = RB; m_valid = (RB == 0); m_boot = 1'b0;
        end else begin
            m_flush = 1'b0;
            if (m_boot) begin
                m_boot = 1'b0; m_valid = 1'b1;
            end else if (!s) begin
                if (m_bub > 0) begin
                    m_bub = m_bub - 1;
                    if (m_bub == 0) m_valid = 1'b1;
                end else begin
                    m_pc = PC_W'((int'(m_pc) + 1) % 4096);
                end
            end
        end
    endfunction

    typedef struct {
        logic            stall;
        logic            br;
        logic [PC_W-1:0] bpc;
        logic            halt;
        logic [PC_W-1:0] epc;
        logic            ev;
        logic            ef;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic s, input logic b, input logic [PC_W-1:0] p,
                                input logic h, input logic [PC_W-1:0] epc,
                                input logic ev, input logic ef);
        vec_t v;
        v.stall = s; v.br = b; v.bpc = p; v.halt = h;
        v.epc = epc; v.ev = ev; v.ef = ef;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic            s;
        logic            b;
        logic            h;
        logic [PC_W-1:0] p;

        rst = 1'b1;
        stall = 1'b0; br = 1'b0; halt = 1'b0; bpc = '0; src_pc = '0;

        // From BOOT: count up, stall at 005, branch under stall, wrap, redirects, halt.
        add(0, 0, 12'h000, 0, 12'h000, 1, 0);
        add(0, 0, 12'h000, 0, 12'h001, 1, 0);
        add(0, 0, 12'h000, 0, 12'h002, 1, 0);
        add(0, 0, 12'h000, 0, 12'h003, 1, 0);
        add(0, 0, 12'h000, 0, 12'h004, 1, 0);
        add(0, 0, 12'h000, 0, 12'h005, 1, 0);
        add(1, 0, 12'h000, 0, 12'h005, 1, 0);
        add(1, 0, 12'h000, 0, 12'h005, 1, 0);
        add(1, 0, 12'h000, 0, 12'h005, 1, 0);
        add(0, 0, 12'h000, 0, 12'h006, 1, 0);
        add(0, 1, 12'h010, 0, 12'h010, 0, 1);
        add(0, 0, 12'h000, 0, 12'h010, 1, 0);
        add(1, 1, 12'h040, 0, 12'h040, 0, 1);
        add(0, 0, 12'h000, 0, 12'h040, 1, 0);
        add(0, 0, 12'h000, 0, 12'h041, 1, 0);
        add(0, 1, 12'hffe, 0, 12'hffe, 0, 1);
        add(0, 0, 12'h000, 0, 12'hffe, 1, 0);
        add(0, 0, 12'h000, 0, 12'hfff, 1, 0);
        add(0, 0, 12'h000, 0, 12'h000, 1, 0);
        add(0, 1, 12'h100, 0, 12'h100, 0, 1);
        add(0, 1, 12'h200, 0, 12'h200, 0, 1);
        add(0, 0, 12'h000, 0, 12'h200, 1, 0);
        add(0, 1, 12'h300, 0, 12'h300, 0, 1);
        add(1, 0, 12'h000, 0, 12'h300, 0, 0);
        add(0, 0, 12'h000, 0, 12'h300, 1, 0);
        add(0, 0, 12'h000, 0, 12'h301, 1, 0);
        add(0, 1, 12'h020, 0, 12'h020, 0, 1);
        add(0, 0, 12'h000, 0, 12'h020, 1, 0);
        add(0, 0, 12'h000, 1, 12'h020, 0, 0);
        add(0, 1, 12'h100, 0, 12'h020, 0, 0);
        add(0, 0, 12'h000, 0, 12'h020, 0, 0);

        do_reset("rst0");
        foreach (vecs[i]) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].halt, vecs[i].bpc);
            expect_out($sformatf("vec%0d", i), vecs[i].epc, vecs[i].ev, vecs[i].ef);
        end

        // Reset while halted restarts from BOOT at RESET_PC.
        do_reset("rst_halt");
        drive(0, 0, 0, 12'h000);
        expect_out("post_halt0", 12'h000, 1'b1, 1'b0);
        drive(0, 0, 0, 12'h000);
        expect_out("post_halt1", 12'h001, 1'b1, 1'b0);

        // Halt and branch on the same edge: halt wins, no flush, PC frozen.
        drive(0, 1, 1, 12'h123);
        expect_out("halt_vs_br", 12'h001, 1'b0, 1'b0);
        drive(0, 0, 0, 12'h000);
        expect_out("halt_hold", 12'h001, 1'b0, 1'b0);

        // Randomized episodes against the reference model.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset($sformatf("rnd%0d", ep));
            model_reset();
            for (int c = 0; c < 200; c++) begin
                s = ($urandom_range(0, 99) < 30);
                b = ($urandom_range(0, 99) < 12);
                h = ($urandom_range(0, 149) == 0);
                if ($urandom_range(0, 3) == 0) p = PC_W'(12'hffc + $urandom_range(0, 3));
                else p = PC_W'($urandom_range(0, 4095));
                model_step(s, b, h, p);
                drive(s, b, h, p);
                expect_out($sformatf("rnd%0d.c%0d", ep, c), m_pc, m_valid, m_flush);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
